mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 4:1 enable-gated, tri-stated mux output line among 4 requesters.
//  Drives the mux select and enable so at most one requester owns the line at a time.
//  Bounds each ownership to MAX_HOLD cycles.
//  Inserts one idle turnaround cycle (enable low, line high-Z) between successive owners.
//  Sits between the requesting sources and the mux instance; all outputs are registered.
// PARAMETERS
//  MAX_HOLD   8   max consecutive grant cycles per ownership; legal range 1..255
//  CW         8   hold-counter width; must satisfy 2**CW > MAX_HOLD
// PORTS
//  clk         in   1  single clock, all logic on rising edge
//  rst_n       in   1  reset, synchronous, active-low
//  req         in   4  level requests, req[k] = requester k wants the line
//  grant       out  4  one-hot owner, 0 when no owner
//  mux_sel     out  2  mux select code for current owner
//  mux_en      out  1  mux enable; 0 => mux output high-Z
//  busy        out  1  1 while in GRANT or GAP
//  preempt     out  1  1-cycle pulse when ownership ends by MAX_HOLD timeout
// BEHAVIOUR
//  Select encoding, fixed:
//    owner 0 -> 2'b10, 1 -> 2'b11, 2 -> 2'b01, 3 -> 2'b00.
//  Reset, sampled at clk edge while rst_n=0:
//    state=IDLE, grant=0, mux_en=0, mux_sel=2'b00, busy=0, preempt=0, hold_cnt=0, last_owner=3.
//    Applies from any state, including mid-GRANT; outputs are zero after that edge.
//  Round-robin pick:
//    First set req bit scanning last_owner+1, +2, +3, +4 (mod 4).
//    The previous owner therefore has lowest priority.
//  IDLE:
//    req==0 -> stay.
//    Otherwise -> GRANT to the RR winner; grant/mux_sel/mux_en valid the cycle after req is sampled.
//    Latency is 1 cycle.
//  GRANT:
//    grant=onehot(owner), mux_en=1, busy=1. hold_cnt increments each cycle from 0.
//    Exit to GAP when req[owner]==0, or when hold_cnt==MAX_HOLD-1 (owner has held MAX_HOLD cycles).
//    Timeout exit with req[owner] still 1 -> preempt=1 in the first GAP cycle.
//    Release and timeout on the same edge count as timeout: preempt=1 only if req[owner] is still 1.
//    On exit: last_owner<=owner, hold_cnt<=0.
//    Requests from other requesters never shorten the current grant.
//  GAP (exactly 1 cycle):
//    grant=0, mux_en=0, mux_sel holds its last value, busy=1.
//    At the end-of-GAP edge, req is re-evaluated with the updated last_owner:
//      any req -> GRANT to the new winner; none -> IDLE.
//    A request arriving during the GAP cycle is eligible.
//    A sole requester is re-granted after the gap.
//  Invariants:
//    grant is 0 or one-hot.
//    mux_en==|grant.
//    mux_en is never 1 for two consecutive owners without a GAP cycle between them.
//    preempt is never high for more than 1 cycle.
//  req bits of non-owners may toggle freely. A glitch on req[owner] of >=1 sampled cycle ends ownership.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, mux_en=0, mux_sel=00, busy=0, preempt=0.
//  2 Single requester: req=4'b0100 for 3 cycles then 0 -> one cycle later grant=0100, mux_sel=01, mux_en=1
//    for 3 cycles; then 1 GAP cycle (busy=1, mux_en=0); then IDLE; preempt never 1.
//  3 Full contention, MAX_HOLD=4, req=4'b1111 held:
//    grants 0001,0010,0100,1000,0001, each 4 cycles;
//    mux_sel 10,11,01,00,10; 1 GAP cycle between grants with preempt=1 in each GAP.
//  4 Sole hog, MAX_HOLD=4, req=4'b0010 held -> grant=0010 for 4 cycles, GAP with preempt=1,
//    grant=0010 again, repeating.
//  5 Reset mid-grant: owner 2 granted, drop rst_n for 1 edge -> outputs 0 next cycle;
//    release with req=4'b1111 -> grant=0001 (last_owner reset to 3).
//  6 Late request: owner 0 drops req; req=4'b1000 first asserted during the GAP cycle
//    -> grant=1000, mux_sel=00 immediately after the GAP, no IDLE cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 enable-gated mux line.
// Ownership is bounded by MAX_HOLD cycles, and a one-cycle idle gap separates successive owners.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] mux_sel,
    output logic       mux_en,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state_reg;
    logic [1:0]    owner_reg;
    logic [1:0]    last_owner_reg;
    logic [CW-1:0] hold_cnt_reg;
    logic [3:0]    grant_reg;
    logic [1:0]    mux_sel_reg;
    logic          mux_en_reg;
    logic          busy_reg;
    logic          preempt_reg;

    logic [3:0]    rot_req;
    logic [1:0]    win_off;
    logic [1:0]    winner;
    logic [1:0]    winner_sel;
    logic          timeout;

    // rot_req[0] is the requester immediately after the last owner, so it has top priority.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[last_owner_reg + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) win_off = 2'(i);
        end
        winner = last_owner_reg + win_off + 2'd1;
        case (winner)
            2'd0:    winner_sel = 2'b10;
            2'd1:    winner_sel = 2'b11;
            2'd2:    winner_sel = 2'b01;
            default: winner_sel = 2'b00;
        endcase
    end

    assign timeout = (hold_cnt_reg == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= 2'd0;
            last_owner_reg <= 2'd3;
            hold_cnt_reg   <= '0;
            grant_reg      <= 4'b0000;
            mux_sel_reg    <= 2'b00;
            mux_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            preempt_reg    <= 1'b0;
        end else begin
            preempt_reg <= 1'b0;
            case (state_reg)
                IDLE, GAP: begin
                    if (|req) begin
                        state_reg    <= GRANT;
                        owner_reg    <= winner;
                        grant_reg    <= 4'b0001 << winner;
                        mux_sel_reg  <= winner_sel;
                        mux_en_reg   <= 1'b1;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[owner_reg] || timeout) begin
                        state_reg      <= GAP;
                        grant_reg      <= 4'b0000;
                        mux_en_reg     <= 1'b0;
                        preempt_reg    <= timeout && req[owner_reg];
                        last_owner_reg <= owner_reg;
                        hold_cnt_reg   <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    grant_reg  <= 4'b0000;
                    mux_en_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_reg;
    assign mux_sel = mux_sel_reg;
    assign mux_en  = mux_en_reg;
    assign busy    = busy_reg;
    assign preempt = preempt_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios followed by random requests,
// checked cycle by cycle against a behavioural ownership model.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] mux_sel;
    logic       mux_en;
    logic       busy;
    logic       preempt;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .mux_sel (mux_sel),
        .mux_en  (mux_en),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       en;
        logic       busy;
        logic       preempt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 0;

    // Behavioural model: who owns the line, for how long, and whether we are in the gap.
    int         m_phase = 0;   // 0 idle, 1 owned, 2 gap
    int         m_owner = 0;
    int         m_held  = 0;
    int         m_last  = 3;
    logic [1:0] m_sel   = 2'b00;
    bit         m_pre   = 0;

    function automatic logic [1:0] sel_code(input int k);
        logic [1:0] codes [4];
        codes[0] = 2'b10; codes[1] = 2'b11; codes[2] = 2'b01; codes[3] = 2'b00;
        return codes[k];
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rn);
        int w;
        exp_t e;
        if (!rn) begin
            m_phase = 0; m_last = 3; m_held = 0; m_sel = 2'b00; m_pre = 0;
        end else begin
            m_pre = 0;
            if (m_phase == 1) begin
                m_held++;
                if (!r[m_owner] || m_held == MAX_HOLD) begin
                    m_pre   = (m_held == MAX_HOLD) && r[m_owner];
                    m_last  = m_owner;
                    m_phase = 2;
                end
            end else begin
                w = rr_pick(r, m_last);
                if (w >= 0) begin
                    m_owner = w; m_held = 0; m_phase = 1; m_sel = sel_code(w);
                end else begin
                    m_phase = 0;
                end
            end
        end
        e.grant   = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.sel     = m_sel;
        e.en      = (m_phase == 1);
        e.busy    = (m_phase != 0);
        e.preempt = m_pre;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [3:0] r, input logic rn, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            req   = r;
            rst_n = rn;
            model_step(r, rn);
        end
    endtask

    // Monitor: each pushed expectation is the DUT state right after the next rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({grant, mux_sel, mux_en, busy, preempt} !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got grant=%b sel=%b en=%b busy=%b preempt=%b, want grant=%b sel=%b en=%b busy=%b preempt=%b",
                             vectors, grant, mux_sel, mux_en, busy, preempt,
                             e.grant, e.sel, e.en, e.busy, e.preempt);
                end
            end
        end
    end

    initial begin : stimulus
        // reset with all requests up
        apply(4'b1111, 1'b0, 2);
        // single requester for three cycles
        apply(4'b0100, 1'b1, 3);
        apply(4'b0000, 1'b1, 4);
        // full contention across several rotations
        apply(4'b1111, 1'b1, 27);
        apply(4'b0000, 1'b1, 3);
        // sole hog repeatedly timed out and re-granted
        apply(4'b0010, 1'b1, 16);
        apply(4'b0000, 1'b1, 3);
        // reset in the middle of owner 2's grant, then contention from owner 0
        apply(4'b0000, 1'b0, 1);
        apply(4'b0100, 1'b1, 3);
        apply(4'b1111, 1'b0, 1);
        apply(4'b1111, 1'b1, 6);
        apply(4'b0000, 1'b1, 3);
        // late request appearing during the gap
        apply(4'b0000, 1'b0, 1);
        apply(4'b0001, 1'b1, 2);
        apply(4'b0000, 1'b1, 1);
        apply(4'b1000, 1'b1, 3);
        apply(4'b0000, 1'b1, 3);
        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            apply(4'($urandom_range(0, 15)), ($urandom_range(0, 49) != 0), 1);
        end
        apply(4'b0000, 1'b1, 2);
        stim_done = 1;
    end

    initial begin : finisher
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #5;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
